// File: rtl/qdr_vacc_readout.sv
// QDR vector-accumulator readback capture, index tagging, overflow-recovering FIFO and ready/valid output.
// Optional status counters (vec_cnt, drop_cnt, max_level) are enabled by defining QDR_VACC_READOUT_STATUS_EN.
module qdr_vacc_readout #(
  parameter int unsigned DATA_WIDTH      = 36,
  parameter int unsigned VEC_LEN         = 4000,
  parameter int unsigned VEC_LEN_BITS    = 12,
  parameter int unsigned FIFO_DEPTH_BITS = 5
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       ce,
  input  logic                       din_vld,
  input  logic [DATA_WIDTH-1:0]      din,
  input  logic                       acc_sync,
  output logic [DATA_WIDTH-1:0]      m_tdata,
  output logic                       m_tvalid,
  input  logic                       m_tready,
  output logic                       m_tfirst,
  output logic                       m_tlast,
  output logic [FIFO_DEPTH_BITS:0]   fifo_level,
  output logic                       ovf
`ifdef QDR_VACC_READOUT_STATUS_EN
  ,
  output logic [31:0]                vec_cnt,
  output logic [15:0]                drop_cnt,
  output logic [FIFO_DEPTH_BITS:0]   max_level
`endif
);

  localparam int unsigned DEPTH = 1 << FIFO_DEPTH_BITS;
  localparam int unsigned EW    = DATA_WIDTH + 2;
  localparam logic [VEC_LEN_BITS-1:0]  LAST_IDX = VEC_LEN_BITS'(VEC_LEN - 1);
  localparam logic [FIFO_DEPTH_BITS:0] FULL_LVL = (FIFO_DEPTH_BITS + 1)'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_STREAM, S_DROP} state_t;

  state_t                      state_q, state_d, state_eff;
  logic [VEC_LEN_BITS-1:0]     idx_q, idx_d, cur_idx;
  logic                        cap_vld_q, cap_vld_d, cap_sync_q, cap_sync_d;
  logic                        cap_first_q, cap_first_d, cap_last_q, cap_last_d;
  logic [DATA_WIDTH-1:0]       cap_data_q, cap_data_d;
  logic                        ovf_q, ovf_d;
  logic [FIFO_DEPTH_BITS:0]    level_q, level_d;
  logic [FIFO_DEPTH_BITS-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [EW-1:0]               mem_q [DEPTH];
  logic                        out_vld_q, out_vld_d, out_first_q, out_first_d, out_last_q, out_last_d;
  logic [DATA_WIDTH-1:0]       out_data_q, out_data_d;
  logic                        pop, full, wr_en, head_avail;

  // Capture valid/sync are one-shot pulses; data and tags hold while ce is low.
  always_comb begin
    cur_idx     = acc_sync ? '0 : idx_q;
    idx_d       = idx_q;
    cap_vld_d   = 1'b0;
    cap_sync_d  = 1'b0;
    cap_data_d  = cap_data_q;
    cap_first_d = cap_first_q;
    cap_last_d  = cap_last_q;
    if (ce) begin
      cap_vld_d   = din_vld;
      cap_sync_d  = acc_sync;
      cap_data_d  = din;
      cap_first_d = (cur_idx == '0);
      cap_last_d  = (cur_idx == LAST_IDX);
      if (din_vld) idx_d = (cur_idx == LAST_IDX) ? '0 : cur_idx + 1'b1;
      else         idx_d = cur_idx;
    end
  end

  assign pop  = out_vld_q & m_tready;
  assign full = (level_q == FULL_LVL);

  // A captured sync re-enters STREAM for the word captured alongside it.
  always_comb begin
    state_eff = cap_sync_q ? S_STREAM : state_q;
    state_d   = state_eff;
    wr_en     = 1'b0;
    ovf_d     = ovf_q;
    case (state_eff)
      S_STREAM: begin
        if (cap_vld_q) begin
          if (full && !pop) begin
            ovf_d   = 1'b1;
            state_d = cap_last_q ? S_STREAM : S_DROP;
          end else begin
            wr_en = 1'b1;
          end
        end
      end
      S_DROP: begin
        if (cap_vld_q && cap_last_q) state_d = S_STREAM;
      end
      default: ;
    endcase
  end

  // Head entry stays in memory (and in fifo_level) until it transfers; the output register mirrors it.
  always_comb begin
    level_d     = level_q + (FIFO_DEPTH_BITS + 1)'(wr_en) - (FIFO_DEPTH_BITS + 1)'(pop);
    wr_ptr_d    = wr_ptr_q + FIFO_DEPTH_BITS'(wr_en);
    rd_ptr_d    = rd_ptr_q + FIFO_DEPTH_BITS'(pop);
    head_avail  = pop ? (level_q > 1) : (level_q != '0);
    out_vld_d   = out_vld_q;
    out_data_d  = out_data_q;
    out_first_d = out_first_q;
    out_last_d  = out_last_q;
    if (!out_vld_q || pop) begin
      out_vld_d = head_avail;
      if (head_avail) {out_first_d, out_last_d, out_data_d} = mem_q[rd_ptr_d];
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= {cap_first_q, cap_last_q, cap_data_q};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      cap_vld_q   <= 1'b0;
      cap_sync_q  <= 1'b0;
      cap_first_q <= 1'b0;
      cap_last_q  <= 1'b0;
      cap_data_q  <= '0;
      ovf_q       <= 1'b0;
      level_q     <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      out_vld_q   <= 1'b0;
      out_first_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cap_vld_q   <= cap_vld_d;
      cap_sync_q  <= cap_sync_d;
      cap_first_q <= cap_first_d;
      cap_last_q  <= cap_last_d;
      cap_data_q  <= cap_data_d;
      ovf_q       <= ovf_d;
      level_q     <= level_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      out_vld_q   <= out_vld_d;
      out_first_q <= out_first_d;
      out_last_q  <= out_last_d;
      out_data_q  <= out_data_d;
    end
  end

  assign m_tdata    = out_data_q;
  assign m_tvalid   = out_vld_q;
  assign m_tfirst   = out_first_q;
  assign m_tlast    = out_last_q;
  assign fifo_level = level_q;
  assign ovf        = ovf_q;

`ifdef QDR_VACC_READOUT_STATUS_EN
  logic [31:0]              vec_cnt_q, vec_cnt_d;
  logic [15:0]              drop_cnt_q, drop_cnt_d;
  logic [FIFO_DEPTH_BITS:0] max_level_q, max_level_d;
  logic                     drop;

  always_comb begin
    drop        = cap_vld_q && ((state_eff == S_DROP) || (state_eff == S_STREAM && full && !pop));
    vec_cnt_d   = vec_cnt_q + 32'(pop & out_last_q);
    drop_cnt_d  = (drop && drop_cnt_q != '1) ? drop_cnt_q + 1'b1 : drop_cnt_q;
    max_level_d = (level_d > max_level_q) ? level_d : max_level_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vec_cnt_q   <= '0;
      drop_cnt_q  <= '0;
      max_level_q <= '0;
    end else begin
      vec_cnt_q   <= vec_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
      max_level_q <= max_level_d;
    end
  end

  assign vec_cnt   = vec_cnt_q;
  assign drop_cnt  = drop_cnt_q;
  assign max_level = max_level_q;
`endif

endmodule

// File: tb/tb_qdr_vacc_readout.sv
// Directed bench for qdr_vacc_readout with VEC_LEN=8, FIFO depth 8: vector table plus scoreboarded sequences.
module tb_qdr_vacc_readout;
  localparam int unsigned DW = 36;

  logic          clk = 1'b0;
  logic          rst, ce, din_vld, acc_sync, m_tready;
  logic [DW-1:0] din, m_tdata;
  logic          m_tvalid, m_tfirst, m_tlast, ovf;
  logic [3:0]    fifo_level;
`ifdef QDR_VACC_READOUT_STATUS_EN
  logic [31:0]   vec_cnt;
  logic [15:0]   drop_cnt;
  logic [3:0]    max_level;
`endif

  qdr_vacc_readout #(
    .DATA_WIDTH(DW), .VEC_LEN(8), .VEC_LEN_BITS(3), .FIFO_DEPTH_BITS(3)
  ) dut (
    .clk(clk), .rst(rst), .ce(ce), .din_vld(din_vld), .din(din), .acc_sync(acc_sync),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready),
    .m_tfirst(m_tfirst), .m_tlast(m_tlast), .fifo_level(fifo_level), .ovf(ovf)
`ifdef QDR_VACC_READOUT_STATUS_EN
    , .vec_cnt(vec_cnt), .drop_cnt(drop_cnt), .max_level(max_level)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  typedef logic [DW+1:0] item_t;  // {first, last, data}
  item_t got[$];
  item_t exp_q[$];
  logic  stall_pend = 1'b0;
  item_t held;

  typedef struct {
    logic          vld;
    logic          sync;
    logic [DW-1:0] din;
    logic          exp_vld;
    logic [DW-1:0] exp_data;
    logic          exp_first;
    logic          exp_last;
    logic [3:0]    exp_level;
  } vec_t;
  vec_t tbl[13];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  // Applies inputs for the coming edge, records the transfer happening at that edge, checks stall stability.
  task automatic step(input logic vld, input logic [DW-1:0] d, input logic sync, input logic rdy);
    din_vld = vld; din = d; acc_sync = sync; m_tready = rdy;
    if (stall_pend) begin
      chk("stall_valid_hold", m_tvalid, 1'b1);
      chk("stall_data_hold", {m_tfirst, m_tlast, m_tdata}, held);
    end
    if (m_tvalid && m_tready) got.push_back({m_tfirst, m_tlast, m_tdata});
    stall_pend = m_tvalid && !m_tready;
    held       = {m_tfirst, m_tlast, m_tdata};
    @(posedge clk); #1;
  endtask

  task automatic push_exp(input logic [DW-1:0] d, input logic f, input logic l);
    exp_q.push_back({f, l, d});
  endtask

  task automatic sb_check(input string name);
    chk({name, "_count"}, 64'(got.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) chk(name, got[i], exp_q[i]);
    got.delete();
    exp_q.delete();
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, rdy);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    stall_pend = 1'b0;
    got.delete();
    exp_q.delete();
  endtask

  initial begin
    int lvl_max;
    logic rdy;
    rst = 1'b0; ce = 1'b1; din_vld = 1'b0; din = '0; acc_sync = 1'b0; m_tready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_tvalid", m_tvalid, 1'b0);
    chk("reset_tdata", m_tdata, '0);
    chk("reset_tags", {m_tfirst, m_tlast}, 2'b00);
    chk("reset_level", fifo_level, 4'd0);
    chk("reset_ovf", ovf, 1'b0);
    rst = 1'b1;

    // Test 1: sync then words 0..7 back to back; first output two edges after the first captured word.
    for (int r = 0; r < 13; r++) begin
      tbl[r].sync      = (r == 0);
      tbl[r].vld       = (r >= 1 && r <= 8);
      tbl[r].din       = (r >= 1 && r <= 8) ? DW'(r - 1) : '0;
      tbl[r].exp_vld   = (r >= 3 && r <= 10);
      tbl[r].exp_data  = DW'(r - 3);
      tbl[r].exp_first = (r == 3);
      tbl[r].exp_last  = (r == 10);
      tbl[r].exp_level = (r < 2) ? 4'd0 : (r == 2) ? 4'd1 : (r <= 9) ? 4'd2 : (r == 10) ? 4'd1 : 4'd0;
    end
    for (int r = 0; r < 13; r++) begin
      step(tbl[r].vld, tbl[r].din, tbl[r].sync, 1'b1);
      chk($sformatf("t1_valid_r%0d", r), m_tvalid, tbl[r].exp_vld);
      chk($sformatf("t1_level_r%0d", r), fifo_level, tbl[r].exp_level);
      if (tbl[r].exp_vld)
        chk($sformatf("t1_word_r%0d", r), {m_tfirst, m_tlast, m_tdata},
            {tbl[r].exp_first, tbl[r].exp_last, tbl[r].exp_data});
    end
    chk("t1_ovf", ovf, 1'b0);
    got.delete();

    // Test 2: words before any sync are discarded.
    do_reset();
    for (int i = 0; i < 5; i++) step(1'b1, DW'(36'h0F0 + i), 1'b0, 1'b1);
    idle(6, 1'b1);
    chk("t2_presync_none", 64'(got.size()), 64'd0);
    chk("t2_presync_level", fifo_level, 4'd0);
    step(1'b0, '0, 1'b1, 1'b1);
    for (int i = 0; i < 8; i++) begin
      step(1'b1, DW'(36'h100 + i), 1'b0, 1'b1);
      push_exp(DW'(36'h100 + i), i == 0, i == 7);
    end
    idle(12, 1'b1);
    sb_check("t2_stream");
`ifdef QDR_VACC_READOUT_STATUS_EN
    chk("t2_vec_cnt", vec_cnt, 32'd1);
`endif

    // Test 3: stalled output, 12 words into an 8-deep FIFO.
    step(1'b0, '0, 1'b1, 1'b0);
    for (int i = 0; i < 12; i++) step(1'b1, DW'(36'h200 + i), 1'b0, 1'b0);
    idle(3, 1'b0);
    chk("t3_level_full", fifo_level, 4'd8);
    chk("t3_ovf", ovf, 1'b1);
    chk("t3_head", {m_tvalid, m_tfirst, m_tlast, m_tdata}, {3'b110, DW'(36'h200)});
`ifdef QDR_VACC_READOUT_STATUS_EN
    chk("t3_drop_cnt", drop_cnt, 16'd4);
    chk("t3_max_level", max_level, 4'd8);
`endif
    for (int i = 0; i < 8; i++) push_exp(DW'(36'h200 + i), i == 0, i == 7);
    idle(12, 1'b1);
    step(1'b0, '0, 1'b1, 1'b1);
    for (int i = 0; i < 8; i++) begin
      step(1'b1, DW'(36'h300 + i), 1'b0, 1'b1);
      push_exp(DW'(36'h300 + i), i == 0, i == 7);
    end
    idle(12, 1'b1);
    sb_check("t3_recover");
    chk("t3_ovf_sticky", ovf, 1'b1);
`ifdef QDR_VACC_READOUT_STATUS_EN
    chk("t3_vec_cnt", vec_cnt, 32'd3);
`endif

    // Test 4: sync coincident with a word mid-vector restarts the index at that word.
    step(1'b0, '0, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, DW'(36'h400 + i), 1'b0, 1'b1);
      push_exp(DW'(36'h400 + i), i == 0, 1'b0);
    end
    step(1'b1, DW'(36'hA5), 1'b1, 1'b1);
    push_exp(DW'(36'hA5), 1'b1, 1'b0);
    for (int i = 0; i < 7; i++) begin
      step(1'b1, DW'(36'h500 + i), 1'b0, 1'b1);
      push_exp(DW'(36'h500 + i), 1'b0, i == 6);
    end
    idle(12, 1'b1);
    sb_check("t4_resync");

    // Test 5: three back-to-back vectors with a randomly toggling ready.
    lvl_max = 0;
    step(1'b0, '0, 1'b1, 1'b1);
    for (int i = 0; i < 24; i++) begin
      rdy = (fifo_level >= 4'd5) ? 1'b1 : ($urandom_range(0, 3) != 0);
      step(1'b1, DW'(36'h600 + i), 1'b0, rdy);
      push_exp(DW'(36'h600 + i), (i % 8) == 0, (i % 8) == 7);
      if (int'(fifo_level) > lvl_max) lvl_max = int'(fifo_level);
    end
    for (int i = 0; i < 20; i++) begin
      step(1'b0, '0, 1'b0, $urandom_range(0, 1) != 0);
    end
    idle(12, 1'b1);
    chk("t5_level_below_full", lvl_max < 8, 1'b1);
    sb_check("t5_random_ready");

    // ce low: input side holds, words and sync are ignored.
    ce = 1'b0;
    step(1'b0, '0, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b1, DW'(36'h700 + i), 1'b0, 1'b1);
    ce = 1'b1;
    idle(6, 1'b1);
    chk("ce_low_none", 64'(got.size()), 64'd0);
    chk("ce_low_level", fifo_level, 4'd0);

    // Test 6: asynchronous reset mid-stream.
    step(1'b0, '0, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) step(1'b1, DW'(36'h800 + i), 1'b0, 1'b0);
    chk("t6_pre_level", fifo_level, 4'd5);
    #2 rst = 1'b0;
    #1;
    chk("t6_async_valid", m_tvalid, 1'b0);
    chk("t6_async_data", m_tdata, '0);
    chk("t6_async_tags", {m_tfirst, m_tlast}, 2'b00);
    chk("t6_async_level", fifo_level, 4'd0);
    chk("t6_async_ovf", ovf, 1'b0);
`ifdef QDR_VACC_READOUT_STATUS_EN
    chk("t6_vec_cnt", vec_cnt, 32'd0);
    chk("t6_drop_cnt", drop_cnt, 16'd0);
`endif
    @(posedge clk); #1;
    rst = 1'b1;
    stall_pend = 1'b0;
    got.delete();
    for (int i = 0; i < 4; i++) step(1'b1, DW'(36'h900 + i), 1'b0, 1'b1);
    idle(8, 1'b1);
    chk("t6_idle_after_reset", 64'(got.size()), 64'd0);
    chk("t6_idle_valid", m_tvalid, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/qdr_vacc_readout.md
Name: qdr_vacc_readout

Overview:
- Sits directly downstream of the QDR vector-accumulator controller.
- Captures accumulated words returned by the QDR while the controller's readback-valid flag is high, indexes them within the vector and tags first/last word.
- Buffers them in a small FIFO and presents a ready/valid stream to the packetiser.
- The QDR readback cannot be stalled, so FIFO overflow is detected, counted and recovered per vector.

Parameters:
- DATA_WIDTH, 36, width of one QDR data word.
- VEC_LEN, 4000, words per accumulated vector.
- VEC_LEN_BITS, 12, width of the word index; 2^VEC_LEN_BITS >= VEC_LEN.
- FIFO_DEPTH_BITS, 5, log2 of FIFO depth (32 entries).

Ports:
- clk  in  1  single clock.
- rst  in  1  asynchronous, active-low reset.
- ce  in  1  input-side clock enable. When low, the capture stage and word counter hold. The output handshake runs regardless.
- din_vld  in  1  QDR read data is a valid accumulated word (the controller's dout_vld).
- din  in  DATA_WIDTH  QDR read data.
- acc_sync  in  1  one-clock strobe; a new accumulation's readback starts at the next valid word.
- m_tdata  out  DATA_WIDTH  output word.
- m_tvalid  out  1  output word valid.
- m_tready  in  1  downstream ready.
- m_tfirst  out  1  word index 0 of a vector.
- m_tlast  out  1  word index VEC_LEN-1 of a vector.
- fifo_level  out  FIFO_DEPTH_BITS+1  current FIFO occupancy.
- ovf  out  1  sticky overflow flag; cleared only by rst.

Behaviour:
- Reset (rst=0, async): FIFO empty, m_tvalid=0, m_tdata=0, m_tfirst=0, m_tlast=0, fifo_level=0, ovf=0, word index=0, FSM=IDLE.
- Capture stage: when ce=1, din/din_vld and the tags are registered once.
  - The FIFO write occurs on the following edge if the FSM permits.
  - Latency with an empty FIFO: din_vld high at edge N gives m_tvalid=1 after edge N+2. The FIFO output is registered (show-ahead).
- Word index: increments on each accepted din_vld with ce=1.
  - Wraps VEC_LEN-1 -> 0.
  - Tag first = (index==0); tag last = (index==VEC_LEN-1).
- acc_sync:
  - Forces the index to 0.
  - If acc_sync and din_vld arrive in the same cycle, that word is index 0 and the index becomes 1.
  - acc_sync is ignored while ce=0.
- FSM states:
  - IDLE: discard words. On acc_sync, go to STREAM.
  - STREAM: write each captured word. If a write is attempted while the FIFO is full, drop the word, set ovf, and go to DROP.
  - DROP: discard words until a word tagged last has been discarded or acc_sync arrives, then go to STREAM. The next vector restarts cleanly at index 0 with m_tfirst.
  - A truncated vector is therefore delivered without m_tlast; the consumer resynchronises on m_tfirst.
- FIFO:
  - Simultaneous read and write when full: the read frees an entry in the same cycle, so the write succeeds and no overflow occurs.
  - Simultaneous read and write when empty: the write is visible one cycle later.
  - fifo_level is exact at every edge.
- Handshake:
  - A word transfers when m_tvalid & m_tready.
  - m_tdata, m_tfirst and m_tlast are held stable while m_tvalid=1 and m_tready=0.
- acc_sync mid-vector in STREAM: the index restarts at 0. Words already in the FIFO are untouched. No m_tlast is emitted for the abandoned vector.

Optional Feature:
- Macro QDR_VACC_READOUT_STATUS_EN.
- When defined, adds the following outputs, all reset to 0 by rst:
  - vec_cnt[31:0]: increments on each m_tlast transfer, wraps.
  - drop_cnt[15:0]: saturating count of discarded words in DROP plus overflowed words.
  - max_level[FIFO_DEPTH_BITS:0]: high-water mark of fifo_level.
- When undefined, these ports and their logic are absent. Core behaviour is identical.

Test Plan (sim overrides: VEC_LEN=8, VEC_LEN_BITS=3, FIFO_DEPTH_BITS=3):
1. rst low, then high; acc_sync; 8 consecutive din_vld with din=0..7; m_tready=1 -> 8 words out, first m_tvalid 2 cycles after the first din_vld; m_tfirst on 0, m_tlast on 7; ovf=0.
2. Words arrive before any acc_sync -> nothing is output. After acc_sync, output starts at index 0.
3. m_tready=0, 12 words after acc_sync -> FIFO holds words 0..7 with fifo_level=8; words 8..11 are dropped; ovf=1. After m_tready=1 and a new acc_sync plus 8 words, the next vector appears with m_tfirst and m_tlast.
4. acc_sync coincident with din_vld (din=0xA5) mid-vector -> 0xA5 is output with m_tfirst=1. The prior partial vector has no m_tlast.
5. Toggle m_tready randomly for 3 back-to-back vectors -> no data reordering or loss when fifo_level never reaches 8; outputs stay stable while stalled.
6. Assert rst low mid-stream -> all outputs are 0 immediately (asynchronously); FSM returns to IDLE; with STATUS_EN, vec_cnt and drop_cnt are 0.
